ex_mem_stage: RTL and testbench

- EX/MEM pipeline register of the 5-stage RISC-V core.
- Captures control bits, ALU result, store data and rd from the EX stage.
- Drives the data-memory/dcache request with a variable-latency req/ack handshake.
- Asserts stall_o to freeze PC, IF/ID and ID/EX while a memory access is outstanding.

---
 rtl/ex_mem_stage.sv | 134 +++++++++++++
 tb/tb_ex_mem_stage.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a variable-latency data-memory handshake.
// Optional stall-cycle counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_stage #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      rs2_data_i,
  input  logic [4:0]       rd_addr_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic [31:0]      alu_result_o,
  output logic [4:0]       rd_addr_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [31:0]      mem_rdata_o,
  output logic             stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        rw_q, mtr_q, mr_q, mw_q;
  logic [31:0] alu_q, wd_q;
  logic [4:0]  rd_q;

  logic busy, stall, mem_in;

  // Handshake decode and timeout bookkeeping
  always_comb begin
    busy   = (state_q == REQ);
    stall  = busy & ~mem_ack_i;
    mem_in = MemRead_i | MemWrite_i;
    tmo_d  = tmo_q;
    err_d  = err_q;
    if (stall) begin
      if (tmo_q != TMO_MAX) tmo_d = tmo_q + 8'd1;
      if (tmo_d == TMO_MAX) err_d = 1'b1;
    end else begin
      tmo_d = 8'd0;
    end
  end

  // Access FSM: a memory op in the register means a request is pending
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tmo_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
      if (!stall) state_q <= mem_in ? REQ : IDLE;
    end
  end

  // Pipeline register: advance whenever not stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rw_q  <= 1'b0;
      mtr_q <= 1'b0;
      mr_q  <= 1'b0;
      mw_q  <= 1'b0;
      alu_q <= 32'd0;
      wd_q  <= 32'd0;
      rd_q  <= 5'd0;
    end else if (!stall) begin
      rw_q  <= RegWrite_i;
      mtr_q <= MemtoReg_i;
      mr_q  <= MemRead_i;
      mw_q  <= MemWrite_i;
      alu_q <= alu_result_i;
      wd_q  <= rs2_data_i;
      rd_q  <= rd_addr_i;
    end
  end

  assign RegWrite_o   = rw_q;
  assign MemtoReg_o   = mtr_q;
  assign MemRead_o    = mr_q;
  assign MemWrite_o   = mw_q;
  assign alu_result_o = alu_q;
  assign rd_addr_o    = rd_q;

  assign mem_req_o   = busy;
  assign mem_we_o    = mw_q;
  assign mem_addr_o  = alu_q;
  assign mem_wdata_o = wd_q;
  assign stall_o     = stall;
  assign err_o       = err_q;

  // A write wins over a simultaneous read, so no load data then
  assign mem_rdata_o =
    (busy & mem_ack_i & mr_q & ~mw_q) ? mem_rdata_i : 32'd0;

`ifdef EX_MEM_STALL_CNT_EN
  logic [CNT_W-1:0] scnt_q;

  // Saturating count of frozen cycles, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scnt_q <= '0;
    end else if (stall && (scnt_q != '1)) begin
      scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = scnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_ex_mem_stage;

  localparam int TMO = 4;
  localparam int CW  = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0]   alu_result_i, rs2_data_i;
  logic [4:0]    rd_addr_i;
  logic          RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic [31:0]   alu_result_o;
  logic [4:0]    rd_addr_o;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i, mem_rdata_o;
  logic          stall_o, err_o;
  logic [CW-1:0] stall_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  ex_mem_stage #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i),
    .rd_addr_i(rd_addr_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .alu_result_o(alu_result_o), .rd_addr_o(rd_addr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_rdata_o(mem_rdata_o), .stall_o(stall_o),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_op(input logic rw, input logic mtr,
                        input logic mr, input logic mw,
                        input logic [31:0] alu,
                        input logic [31:0] wd,
                        input logic [4:0] rd);
    RegWrite_i   = rw;
    MemtoReg_i   = mtr;
    MemRead_i    = mr;
    MemWrite_i   = mw;
    alu_result_i = alu;
    rs2_data_i   = wd;
    rd_addr_i    = rd;
  endtask

  task automatic test_reset;
    logic [7:0] got;
    rst_i = 1'b1;
    set_op(0, 0, 0, 0, 0, 0, 0);
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'd0;
    #1;
    got = {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
           mem_req_o, mem_we_o, stall_o, err_o};
    n_chk++;
    if (got !== 8'h00)
      $display("FAIL reset_ctl got %h exp 00", got);
    else n_pass++;
    n_chk++;
    if ({alu_result_o, rd_addr_o, mem_wdata_o} !== 69'd0)
      $display("FAIL reset_data got %h/%h/%h exp 0",
               alu_result_o, rd_addr_o, mem_wdata_o);
    else n_pass++;
    n_chk++;
    if (stall_cnt_o !== '0)
      $display("FAIL reset_cnt got %0d exp 0", stall_cnt_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_alu;
    @(negedge clk_i);
    set_op(1, 0, 0, 0, 32'h10, 32'h0, 5'd5);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    set_op(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if ({RegWrite_o, rd_addr_o, alu_result_o} !== {1'b1, 5'd5, 32'h10})
      $display("FAIL alu_regs got %b/%0d/%h exp 1/5/10",
               RegWrite_o, rd_addr_o, alu_result_o);
    else n_pass++;
    n_chk++;
    if ({mem_req_o, stall_o} !== 2'b00)
      $display("FAIL alu_req got %b%b exp 00", mem_req_o, stall_o);
    else n_pass++;
  endtask

  task automatic test_load_wait;
    int nreq = 0;
    int nstall = 0;
    @(negedge clk_i);
    set_op(1, 1, 1, 0, 32'h100, 32'h0, 5'd7);
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      set_op(1, 0, 0, 0, 32'h55, 32'h0, 5'd9);
      #1;
      nreq += int'(mem_req_o);
      nstall += int'(stall_o);
      n_chk++;
      if (mem_addr_o !== 32'h100)
        $display("FAIL ld_addr got %h exp 100", mem_addr_o);
      else n_pass++;
    end
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    nreq += int'(mem_req_o);
    nstall += int'(stall_o);
    n_chk++;
    if (mem_rdata_o !== 32'hDEADBEEF)
      $display("FAIL ld_rdata got %h exp deadbeef", mem_rdata_o);
    else n_pass++;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    #1;
    nreq += int'(mem_req_o);
    n_chk++;
    if ((nreq != 4) || (nstall != 3))
      $display("FAIL ld_counts got req %0d stall %0d exp 4 3",
               nreq, nstall);
    else n_pass++;
    n_chk++;
    if ({rd_addr_o, alu_result_o, MemRead_o} !== {5'd9, 32'h55, 1'b0})
      $display("FAIL ld_next got %0d/%h/%b exp 9/55/0",
               rd_addr_o, alu_result_o, MemRead_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk_i);
    set_op(0, 0, 0, 1, 32'h200, 32'h1234, 5'd0);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    set_op(1, 1, 1, 0, 32'h204, 32'h0, 5'd4);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h5555AAAA;
    #1;
    n_chk++;
    if ({mem_req_o, mem_we_o, stall_o, mem_addr_o, mem_wdata_o,
         mem_rdata_o} !== {3'b110, 32'h200, 32'h1234, 32'h0})
      $display("FAIL b2b_st got %b%b%b %h %h %h exp 110 200 1234 0",
               mem_req_o, mem_we_o, stall_o, mem_addr_o,
               mem_wdata_o, mem_rdata_o);
    else n_pass++;
    @(negedge clk_i);
    set_op(0, 0, 0, 0, 0, 0, 0);
    mem_rdata_i = 32'hCAFE0001;
    #1;
    n_chk++;
    if ({mem_req_o, mem_we_o, stall_o, mem_addr_o, mem_rdata_o} !==
        {3'b100, 32'h204, 32'hCAFE0001})
      $display("FAIL b2b_ld got %b%b%b %h %h exp 100 204 cafe0001",
               mem_req_o, mem_we_o, stall_o, mem_addr_o, mem_rdata_o);
    else n_pass++;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    n_chk++;
    if (mem_req_o !== 1'b0)
      $display("FAIL b2b_idle got %b exp 0", mem_req_o);
    else n_pass++;
  endtask

  task automatic test_timeout;
    logic [CW-1:0] exp_cnt;
`ifdef EX_MEM_STALL_CNT_EN
    exp_cnt = CW'(9);
`else
    exp_cnt = '0;
`endif
    @(negedge clk_i);
    set_op(1, 1, 1, 0, 32'h300, 32'h0, 5'd2);
    mem_ack_i = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk_i);
      set_op(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_chk++;
      if ({err_o, stall_o} !== 2'b01)
        $display("FAIL tmo_early%0d got err %b stall %b exp 0 1",
                 k, err_o, stall_o);
      else n_pass++;
    end
    @(negedge clk_i);
    #1;
    n_chk++;
    if ({err_o, mem_req_o, stall_o} !== 3'b111)
      $display("FAIL tmo_set got %b%b%b exp 111",
               err_o, mem_req_o, stall_o);
    else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h0BADF00D;
    #1;
    n_chk++;
    if ({stall_o, mem_rdata_o} !== {1'b0, 32'h0BADF00D})
      $display("FAIL tmo_ack got %b %h exp 0 0badf00d",
               stall_o, mem_rdata_o);
    else n_pass++;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    n_chk++;
    if ({err_o, mem_req_o} !== 2'b10)
      $display("FAIL tmo_sticky got %b%b exp 10", err_o, mem_req_o);
    else n_pass++;
    n_chk++;
    if (stall_cnt_o !== exp_cnt)
      $display("FAIL stall_cnt got %0d exp %0d", stall_cnt_o, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_spurious_ack;
    @(negedge clk_i);
    set_op(1, 0, 0, 0, 32'hABC, 32'h0, 5'd3);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFF0000;
    #1;
    n_chk++;
    if ({mem_req_o, stall_o, mem_rdata_o} !== 34'd0)
      $display("FAIL spur_ack got %b%b %h exp 00 0",
               mem_req_o, stall_o, mem_rdata_o);
    else n_pass++;
    n_chk++;
    if ({RegWrite_o, alu_result_o, rd_addr_o} !== {1'b1, 32'hABC, 5'd3})
      $display("FAIL spur_regs got %b %h %0d exp 1 abc 3",
               RegWrite_o, alu_result_o, rd_addr_o);
    else n_pass++;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if ({mem_req_o, stall_o} !== 2'b00)
      $display("FAIL spur_after got %b%b exp 00", mem_req_o, stall_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_req;
    @(negedge clk_i);
    set_op(1, 1, 1, 0, 32'h400, 32'h0, 5'd6);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    set_op(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if ({mem_req_o, stall_o, err_o} !== 3'b111)
      $display("FAIL mid_pre got %b%b%b exp 111",
               mem_req_o, stall_o, err_o);
    else n_pass++;
    #1 rst_i = 1'b1;
    #1;
    n_chk++;
    if ({mem_req_o, stall_o, err_o, MemRead_o, RegWrite_o,
         MemtoReg_o, alu_result_o, rd_addr_o} !== 43'd0)
      $display("FAIL mid_rst got %b%b%b%b%b%b %h %0d exp 0",
               mem_req_o, stall_o, err_o, MemRead_o, RegWrite_o,
               MemtoReg_o, alu_result_o, rd_addr_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_chk++;
    if ({mem_req_o, stall_o} !== 2'b00)
      $display("FAIL mid_idle got %b%b exp 00", mem_req_o, stall_o);
    else n_pass++;
  endtask

  task automatic test_random;
    logic          m_rw, m_mtr, m_mr, m_mw;
    logic [31:0]   m_alu, m_wd;
    logic [4:0]    m_rd;
    int            m_wait;
    logic          m_err;
    logic [CW-1:0] m_cnt;
    logic          pend, frz;
    logic [72:0]   got_r, exp_r;
    logic [66:0]   got_m, exp_m;
    logic [CW:0]   got_s, exp_s;
    int            r;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    {m_rw, m_mtr, m_mr, m_mw} = 4'b0;
    m_alu = 0; m_wd = 0; m_rd = 0;
    m_wait = 0; m_err = 0; m_cnt = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      r = $urandom_range(0, 7);
      set_op(1'($urandom), 1'($urandom), 1'b0, 1'b0,
             $urandom, $urandom, 5'($urandom));
      case (r)
        0, 1: set_op(0, 0, 0, 0, $urandom, 0, 0);
        4, 5: MemRead_i = 1'b1;
        6:    MemWrite_i = 1'b1;
        7:    {MemRead_i, MemWrite_i} = 2'b11;
        default: ;
      endcase
      mem_ack_i = ($urandom_range(0, 3) != 0);
      mem_rdata_i = $urandom;
      #1;
      pend = m_mr | m_mw;
      frz  = pend & ~mem_ack_i;
      exp_r = {m_rw, m_mtr, m_mr, m_mw, m_rd, m_alu, m_wd};
      got_r = {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
               rd_addr_o, alu_result_o, mem_wdata_o};
      exp_m = {pend, m_mw, frz, m_alu,
               (pend & mem_ack_i & m_mr & ~m_mw) ? mem_rdata_i : 32'd0};
      got_m = {mem_req_o, mem_we_o, stall_o, mem_addr_o, mem_rdata_o};
`ifdef EX_MEM_STALL_CNT_EN
      exp_s = {m_err, m_cnt};
`else
      exp_s = {m_err, {CW{1'b0}}};
`endif
      got_s = {err_o, stall_cnt_o};
      n_chk++;
      if (got_r !== exp_r)
        $display("FAIL rnd_regs c%0d got %h exp %h", c, got_r, exp_r);
      else n_pass++;
      n_chk++;
      if (got_m !== exp_m)
        $display("FAIL rnd_mem c%0d got %h exp %h", c, got_m, exp_m);
      else n_pass++;
      n_chk++;
      if (got_s !== exp_s)
        $display("FAIL rnd_stat c%0d got %h exp %h", c, got_s, exp_s);
      else n_pass++;
      if (frz) begin
        if (m_wait < TMO) m_wait++;
        if (m_wait == TMO) m_err = 1'b1;
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end else begin
        m_wait = 0;
        m_rw = RegWrite_i; m_mtr = MemtoReg_i;
        m_mr = MemRead_i;  m_mw = MemWrite_i;
        m_alu = alu_result_i; m_wd = rs2_data_i;
        m_rd = rd_addr_i;
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load_wait;
    test_back_to_back;
    test_timeout;
    test_spurious_ack;
    test_reset_mid_req;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
